catcore_key_vault: RTL

CATCORE_KEY_VAULT -- requirements
Module: catcore_key_vault

---
 rtl/catcore_key_pkg.sv | 61 ++++++
 rtl/catcore_key_rom.sv | 41 ++++
 rtl/catcore_key_vault.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/catcore_key_pkg.sv
// Shared types and constant tables for the key vault: FSM states, unlock codes,
// key lengths and the slot/address byte contents.
package catcore_key_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        DENY   = 2'd3
    } state_e;

    localparam int NUM_SLOTS = 4;
    localparam logic [7:0] LOCK_BYTE = 8'h4C;

    localparam logic [7:0] KEY_CODE [NUM_SLOTS] = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    // Slot 2 is intentionally empty, slot 3 is longer than the address space allows.
    localparam int KEY_LEN [NUM_SLOTS] = '{15, 7, 0, 40};

    localparam logic [8*15-1:0] KEY0_STR = "grey{race_flag}";
    localparam logic [8*7-1:0]  KEY1_STR = "catcore";

    function automatic logic [7:0] key_code(input int slot);
        case (slot)
            0:       return KEY_CODE[0];
            1:       return KEY_CODE[1];
            2:       return KEY_CODE[2];
            3:       return KEY_CODE[3];
            default: return 8'h00;
        endcase
    endfunction

    function automatic int key_len(input int slot);
        case (slot)
            0:       return KEY_LEN[0];
            1:       return KEY_LEN[1];
            2:       return KEY_LEN[2];
            3:       return KEY_LEN[3];
            default: return 0;
        endcase
    endfunction

    // Bytes past a slot's length read as zero, which also covers empty slots.
    function automatic logic [7:0] rom_byte(input int slot, input int addr);
        logic [8*15-1:0] s0;
        logic [8*7-1:0]  s1;
        logic [7:0]      b;
        b  = 8'h00;
        s0 = KEY0_STR >> (8 * (14 - addr));
        s1 = KEY1_STR >> (8 * (6 - addr));
        if (addr < key_len(slot)) begin
            case (slot)
                0:       b = s0[7:0];
                1:       b = s1[7:0];
                3:       b = 8'hA0 + 8'(addr);
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/catcore_key_rom.sv
// Key byte ROM indexed by {slot, addr}; 1-cycle registered read, optional XOR mask.
// ld_lock_i overrides the read and loads the fixed lock byte without touching the ROM.
module catcore_key_rom
    import catcore_key_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int SEL_W  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rd_en_i,
    input  logic                    ld_lock_i,
    input  logic [SEL_W+ADDR_W-1:0] rd_idx_i,
    input  logic [DATA_W-1:0]       mask_i,
    output logic [DATA_W-1:0]       rd_data_o
);

    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (ld_lock_i) begin
            data_d = DATA_W'(LOCK_BYTE);
        end else if (rd_en_i) begin
            data_d = DATA_W'(rom_byte(int'(rd_idx_i[ADDR_W +: SEL_W]),
                                      int'(rd_idx_i[ADDR_W-1:0]))) ^ mask_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rd_data_o = data_q;

endmodule

// File: rtl/catcore_key_vault.sv
// Code-gated key vault streaming one byte per two cycles over valid/ready; outputs held while stalled.
// Define CATCORE_KEY_XOR_EN to XOR streamed bytes with a per-byte rotating mask seeded at start.
module catcore_key_vault
    import catcore_key_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int NUM_KEYS  = 4,
    parameter int MAX_FAILS = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(NUM_KEYS)-1:0] key_sel,
    input  logic                        start,
    input  logic                        unlock_stb,
    input  logic [DATA_W-1:0]           unlock_code,
    input  logic [DATA_W-1:0]           mask_seed,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    output logic [NUM_KEYS-1:0]         unlocked,
    output logic                        lockout
);

    localparam int SEL_W  = $clog2(NUM_KEYS);
    localparam int LEN_W  = ADDR_W + 1;
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAILS);

    function automatic logic [LEN_W-1:0] eff_len(input int slot);
        int len;
        len = key_len(slot);
        if (len > (1 << ADDR_W)) len = 1 << ADDR_W;
        return LEN_W'(len);
    endfunction

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    slot_q, slot_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic                lockout_q, lockout_d;
    logic [NUM_KEYS-1:0] unlocked_q, unlocked_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;

    logic                rom_rd_en, rom_ld_lock;
    logic                load_mask, step_mask;
    logic [DATA_W-1:0]   rom_mask;
    logic [LEN_W-1:0]    slot_len;
    logic                cur_last;
    logic                code_ok;

    assign slot_len = eff_len(int'(slot_q));
    // An empty slot still emits one (zero) byte, so it is always the last.
    assign cur_last = (slot_len == '0) || ({1'b0, addr_q} == slot_len - LEN_W'(1));
    assign code_ok  = (unlock_code == DATA_W'(key_code(int'(key_sel))));

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        addr_d      = addr_q;
        fail_d      = fail_q;
        lockout_d   = lockout_q;
        unlocked_d  = unlocked_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        rom_rd_en   = 1'b0;
        rom_ld_lock = 1'b0;
        load_mask   = 1'b0;
        step_mask   = 1'b0;
        case (state_q)
            IDLE: begin
                if (unlock_stb) begin
                    if (!lockout_q) begin
                        if (code_ok) begin
                            unlocked_d[key_sel] = 1'b1;
                        end else begin
                            if (fail_q != FAIL_MAX) fail_d = fail_q + FAIL_W'(1);
                            if (fail_d == FAIL_MAX) begin
                                lockout_d  = 1'b1;
                                unlocked_d = '0;
                            end
                        end
                    end
                end else if (start) begin
                    if (unlocked_q[key_sel]) begin
                        slot_d    = key_sel;
                        addr_d    = '0;
                        load_mask = 1'b1;
                        state_d   = FETCH;
                    end else begin
                        rom_ld_lock = 1'b1;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
                        state_d     = DENY;
                    end
                end
            end
            FETCH: begin
                rom_rd_en   = 1'b1;
                out_valid_d = 1'b1;
                out_last_d  = cur_last;
                state_d     = STREAM;
            end
            STREAM: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    step_mask   = 1'b1;
                    if (out_last_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            DENY: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            addr_q      <= '0;
            fail_q      <= '0;
            lockout_q   <= 1'b0;
            unlocked_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            addr_q      <= addr_d;
            fail_q      <= fail_d;
            lockout_q   <= lockout_d;
            unlocked_q  <= unlocked_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

`ifdef CATCORE_KEY_XOR_EN
    logic [DATA_W-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (load_mask) begin
            mask_d = mask_seed;
        end else if (step_mask) begin
            mask_d = {mask_q[DATA_W-2:0], mask_q[DATA_W-1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign rom_mask = mask_q;
`else
    logic unused_mask;
    assign unused_mask = ^{mask_seed, load_mask, step_mask};
    assign rom_mask    = '0;
`endif

    catcore_key_rom #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .SEL_W  (SEL_W)
    ) u_rom (
        .clk_i     (clk),
        .rst_i     (rst),
        .rd_en_i   (rom_rd_en),
        .ld_lock_i (rom_ld_lock),
        .rd_idx_i  ({slot_q, addr_q}),
        .mask_i    (rom_mask),
        .rd_data_o (out_data)
    );

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign unlocked  = unlocked_q;
    assign lockout   = lockout_q;

endmodule
